// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between inst and data requesters, data side has fixed priority.
// Zero-cycle forwarding/response routing; stalls (mem_req=0) while OUTST_DEPTH transactions are outstanding.
module sram_like_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [31:0]       inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  outst_cnt,
    output logic              err_spurious
);
    localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t                 state, state_nxt;
    logic                   grant_data;
    logic                   sel_req;
    logic                   full, empty;
    logic                   push, pop;
    logic                   head_id;
    logic [OUTST_DEPTH-1:0] id_q;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       cnt;

    assign grant_data = (state == LOCK_D) || ((state == IDLE) && data_req);
    assign sel_req    = grant_data ? data_req : inst_req;
    assign full       = (cnt == CNT_W'(OUTST_DEPTH));
    assign empty      = (cnt == '0);
    assign push       = mem_req & mem_addr_ok;
    assign pop        = mem_data_ok & ~empty & ~reset;
    assign head_id    = id_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An unaccepted offer locks the mux so the address stays stable until addr_ok.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_nxt = grant_data ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I, LOCK_D: begin
                if (!sel_req || push) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = sel_req & ~full & ~reset;
        mem_wr       = grant_data ? data_wr    : inst_wr;
        mem_size     = grant_data ? data_size  : inst_size;
        mem_wstrb    = grant_data ? data_wstrb : inst_wstrb;
        mem_addr     = grant_data ? data_addr  : inst_addr;
        mem_wdata    = grant_data ? data_wdata : inst_wdata;
        inst_addr_ok = push & ~grant_data;
        data_addr_ok = push & grant_data;
        inst_data_ok = pop & ~head_id;
        data_data_ok = pop & head_id;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // In-order ID FIFO: bit = 1 for data side, 0 for inst side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (push) begin
                id_q[wr_ptr] <= grant_data;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (mem_data_ok && empty) begin
                err_spurious <= 1'b1;
            end
        end
    end

    assign outst_cnt = cnt;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a queue-based reference model.
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  outst_cnt;
    logic        err_spurious;

    int passes = 0;
    int total  = 0;

    sram_like_arbiter #(.OUTST_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int locked, g, hd;
        bit rq, full, emr, acc, pop, err_m, drop_i, drop_d;
        logic [31:0] ea;

        reset = 1'b1;
        {inst_req, inst_wr, data_req, data_wr, mem_addr_ok, mem_data_ok} = '0;
        inst_size = 2'd2; data_size = 2'd2; inst_wstrb = 4'hf; data_wstrb = 4'hf;
        inst_addr = '0; inst_wdata = '0; data_addr = '0; data_wdata = '0;
        mem_rdata = 32'h0000_1234;
        #3;
        chk("rst_cnt", 32'(outst_cnt), 0);
        chk("rst_err", 32'(err_spurious), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
        chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
        chk("rst_rdata", inst_rdata, 32'h0000_1234);
        #4 reset = 1'b0;

        // Single fetch, accepted same cycle, data two cycles later.
        step(); inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1; #1;
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h1c00_0000);
        chk("f_addr_ok", 32'(inst_addr_ok), 1);
        chk("f_cnt0", 32'(outst_cnt), 0);
        step(); inst_req = 0; mem_addr_ok = 0; #1;
        chk("f_cnt1", 32'(outst_cnt), 1);
        step(); mem_data_ok = 1; mem_rdata = 32'h0280_0404; #1;
        chk("f_data_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
        chk("f_rdata", inst_rdata, 32'h0280_0404);
        step(); mem_data_ok = 0; #1;
        chk("f_cnt2", 32'(outst_cnt), 0);

        // Contention: data wins, responses come back data then inst.
        step(); inst_req = 1; inst_addr = 32'h100; data_req = 1; data_wr = 1;
        data_addr = 32'h80; data_wdata = 32'hdead_beef; mem_addr_ok = 1; #1;
        chk("c_mem_addr0", mem_addr, 32'h80);
        chk("c_mem_wr", 32'(mem_wr), 1);
        chk("c_mem_wdata", mem_wdata, 32'hdead_beef);
        chk("c_addr_ok0", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
        step(); data_req = 0; data_wr = 0; #1;
        chk("c_mem_addr1", mem_addr, 32'h100);
        chk("c_addr_ok1", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
        chk("c_resp0", 32'({inst_data_ok, data_data_ok}), 32'b01);
        step(); #1;
        chk("c_resp1", 32'({inst_data_ok, data_data_ok}), 32'b10);
        step(); mem_data_ok = 0; #1;
        chk("c_cnt", 32'(outst_cnt), 0);

        // Lock hold: data address stays on the port while inst_req rises.
        step(); data_req = 1; data_addr = 32'h200; #1;
        chk("l_addr0", mem_addr, 32'h200);
        for (int i = 1; i <= 3; i++) begin
            step(); inst_req = 1; inst_addr = 32'h300; mem_addr_ok = (i == 3); #1;
            chk("l_addr_hold", mem_addr, 32'h200);
            chk("l_addr_ok", 32'({inst_addr_ok, data_addr_ok}), (i == 3) ? 32'b01 : 32'b00);
        end
        step(); data_req = 0; #1;
        chk("l_inst_addr", mem_addr, 32'h300);
        chk("l_inst_ok", 32'(inst_addr_ok), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
        chk("l_resp0", 32'({inst_data_ok, data_data_ok}), 32'b01);
        step(); #1;
        chk("l_resp1", 32'({inst_data_ok, data_data_ok}), 32'b10);
        step(); mem_data_ok = 0; #1;

        // Full: four accepted reads, fifth blocked until the cycle after a pop.
        for (int i = 0; i < 4; i++) begin
            step(); inst_req = 1; inst_addr = 32'h1000 + 32'(i * 4); mem_addr_ok = 1; #1;
            chk("u_accept", 32'(inst_addr_ok), 1);
        end
        step(); inst_addr = 32'h1010; #1;
        chk("u_cnt4", 32'(outst_cnt), 4);
        chk("u_blocked", 32'(mem_req), 0);
        chk("u_no_ok", 32'(inst_addr_ok), 0);
        step(); mem_data_ok = 1; #1;
        chk("u_pop", 32'(inst_data_ok), 1);
        chk("u_blocked_pop", 32'(mem_req), 0);
        step(); mem_data_ok = 0; #1;
        chk("u_cnt3", 32'(outst_cnt), 3);
        chk("u_unblock", 32'(inst_addr_ok), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
        for (int i = 0; i < 4; i++) begin
            chk("u_drain", 32'(inst_data_ok), 1);
            step();
        end
        mem_data_ok = 0; #1;
        chk("u_cnt0", 32'(outst_cnt), 0);

        // Spurious response, then async reset with two outstanding.
        step(); mem_data_ok = 1; #1;
        chk("s_no_ok", 32'({inst_data_ok, data_data_ok}), 0);
        step(); mem_data_ok = 0; #1;
        chk("s_err", 32'(err_spurious), 1);
        chk("s_cnt", 32'(outst_cnt), 0);
        step(); inst_req = 1; mem_addr_ok = 1;
        step(); step(); inst_req = 0; mem_addr_ok = 0; #1;
        chk("r_cnt2", 32'(outst_cnt), 2);
        #1 reset = 1'b1; #1;
        chk("r_cnt", 32'(outst_cnt), 0);
        chk("r_err", 32'(err_spurious), 0);
        #4 reset = 1'b0;
        step(); mem_data_ok = 1; #1;
        chk("r_late_ok", 32'({inst_data_ok, data_data_ok}), 0);
        step(); mem_data_ok = 0; #1;
        chk("r_late_err", 32'(err_spurious), 1);

        // Randomized traffic against the reference model.
        reset = 1'b1; #2 reset = 1'b0;
        q.delete(); locked = -1; err_m = 0; drop_i = 0; drop_d = 0;
        for (int c = 0; c < 1500; c++) begin
            step();
            if (drop_i) inst_req = 0;
            if (drop_d) data_req = 0;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_addr = $urandom; inst_wr = 1'($urandom_range(0, 1));
                inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1; data_addr = $urandom; data_wr = 1'($urandom_range(0, 1));
                data_wdata = $urandom;
            end
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            #1;
            g    = (locked >= 0) ? locked : (data_req ? 1 : (inst_req ? 0 : -1));
            rq   = (g == 1) ? data_req : ((g == 0) ? inst_req : 1'b0);
            ea   = (g == 1) ? data_addr : inst_addr;
            full = (q.size() == 4);
            emr  = rq && !full;
            acc  = emr && mem_addr_ok;
            pop  = mem_data_ok && (q.size() > 0);
            hd   = pop ? q[0] : -1;
            chk("m_mem_req", 32'(mem_req), 32'(emr));
            if (emr) chk("m_mem_addr", mem_addr, ea);
            chk("m_inst_addr_ok", 32'(inst_addr_ok), 32'(acc && g == 0));
            chk("m_data_addr_ok", 32'(data_addr_ok), 32'(acc && g == 1));
            chk("m_inst_data_ok", 32'(inst_data_ok), 32'(hd == 0));
            chk("m_data_data_ok", 32'(data_data_ok), 32'(hd == 1));
            chk("m_cnt", 32'(outst_cnt), 32'(q.size()));
            chk("m_err", 32'(err_spurious), 32'(err_m));
            if (hd >= 0) chk("m_rdata", (hd == 1) ? data_rdata : inst_rdata, mem_rdata);
            if (mem_data_ok && q.size() == 0) err_m = 1;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(g);
            locked = (g >= 0 && rq && !acc && (locked >= 0 || emr)) ? g : -1;
            drop_i = acc && (g == 0);
            drop_d = acc && (g == 1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
